// File: rtl/msk_modulator_param.sv
// -----------------------------------------------------------------------------
// msk_modulator_param
//
// Minimum-shift-keying style baseband modulator. Words are accepted through a
// valid/ready handshake and sent LSB first. Every bit produces SPB samples of a
// half (bit = 1) or full (bit = 0) sine period. A 0/pi carrier phase flips the
// waveform polarity. The phase toggles after every transmitted 1.
//
// Samples are unsigned offset binary centred on MID = 2^(OUT_W-1). The sine
// magnitudes come from two ROMs that are filled at elaboration time.
//
// Optional feature macro: MSK_DIFF_ENC_EN
//   When defined, each transmitted bit is d_i XOR b_(i-1). The previous
//   transmitted bit is kept across words and cleared by reset.
//
// Parameters
//   DATA_W : bits per input word (2..32)
//   SPB    : samples per bit (power of two, 8..64)
//   OUT_W  : output sample width (6..12)
//
// Ports
//   G_CLK_TX  : sample clock, rising edge
//   reset     : asynchronous, active-low reset
//   enable    : clock enable; low freezes all state and gates out_valid/in_ready
//   in_valid  : data_in holds a word to send
//   in_ready  : a word is accepted this cycle
//   data_in   : word to modulate
//   data_out  : registered modulation sample (MID when idle)
//   out_valid : data_out is a live sample
//   word_done : pulse together with the last sample of a word
//   phase_out : current carrier phase state (0 = 0, 1 = pi)
// -----------------------------------------------------------------------------
module msk_modulator_param #(
    parameter int DATA_W = 8,
    parameter int SPB    = 32,
    parameter int OUT_W  = 8
) (
    input  logic              G_CLK_TX,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [OUT_W-1:0]  data_out,
    output logic              out_valid,
    output logic              word_done,
    output logic              phase_out
);

    localparam int  KW  = $clog2(SPB);
    localparam int  BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int  MID = 2 ** (OUT_W - 1);
    localparam int  AMP = MID - 1;
    localparam real PI  = 3.14159265358979323846;

    localparam logic signed [OUT_W+1:0] MID_S   = (OUT_W + 2)'(MID);
    localparam logic signed [OUT_W+1:0] SAT_MAX = (OUT_W + 2)'((2 ** OUT_W) - 1);

    localparam logic [KW-1:0] K_LAST = KW'(SPB - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time helpers (only ever evaluated on constants)
    // -------------------------------------------------------------------------

    // Taylor series sine after folding the argument into [-pi, pi]. The
    // argument range used here is [0, 2*pi], so a single fold is enough.
    function automatic real sine_series(input real x_in);
        real x;
        real term;
        real acc;
        x = x_in;
        if (x > PI)
            x = x - 2.0 * PI;
        if (x < -PI)
            x = x + 2.0 * PI;
        term = x;
        acc  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Round half away from zero.
    function automatic int round_half_away(input real r);
        if (r >= 0.0)
            return $rtoi(r + 0.5);
        else
            return -$rtoi(0.5 - r);
    endfunction

    // Signed magnitude round(AMP * sin(pi*m*k/(SPB-1))).
    function automatic int rom_entry(input int m, input int k);
        return round_half_away(real'(AMP) * sine_series(PI * real'(m * k) / real'(SPB - 1)));
    endfunction

    // Offset-binary conversion clamp to the unsigned OUT_W range.
    function automatic logic [OUT_W-1:0] sat_unsigned(input logic signed [OUT_W+1:0] v);
        if (v < 0)
            return '0;
        else if (v > SAT_MAX)
            return '1;
        else
            return v[OUT_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Sine ROMs: m = 1 (half period, bit 1) and m = 2 (full period, bit 0)
    // -------------------------------------------------------------------------
    logic signed [OUT_W-1:0] rom_m1 [SPB];
    logic signed [OUT_W-1:0] rom_m2 [SPB];

    for (genvar g = 0; g < SPB; g++) begin : g_rom
        localparam int V1 = rom_entry(1, g);
        localparam int V2 = rom_entry(2, g);
        assign rom_m1[g] = OUT_W'(V1);
        assign rom_m2[g] = OUT_W'(V2);
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] word_p0;
    logic [KW-1:0]     k_cnt;
    logic [BW-1:0]     bit_idx;
    logic              phase;
    logic              last_bit;
    logic              last_sample;
    logic              handshake;
    logic              cur_bit;
    logic              tx_bit;

`ifdef MSK_DIFF_ENC_EN
    logic              diff_q;
`endif

    assign last_bit    = (k_cnt == K_LAST);
    assign last_sample = last_bit && (bit_idx == B_LAST);
    assign cur_bit     = word_p0[bit_idx];

`ifdef MSK_DIFF_ENC_EN
    assign tx_bit = cur_bit ^ diff_q;
`else
    assign tx_bit = cur_bit;
`endif

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (enable)
            state <= state_nxt;
    end

    // The last-sample cycle of a word can accept the next word. This keeps
    // back-to-back words gapless.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        handshake = 1'b0;
        if (enable)
            in_ready = (state == IDLE) || last_sample;
        handshake = in_valid && in_ready;
        case (state)
            IDLE: if (handshake) state_nxt = SEND;
            SEND: if (last_sample) state_nxt = handshake ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p0 -> p1: ROM lookup, polarity, offset; register the output sample
    // -------------------------------------------------------------------------
    logic signed [OUT_W-1:0] mag;
    logic signed [OUT_W+1:0] mag_ext;
    logic signed [OUT_W+1:0] sample_sum;

    always_comb begin
        mag        = tx_bit ? rom_m1[k_cnt] : rom_m2[k_cnt];
        mag_ext    = $signed({{2{mag[OUT_W-1]}}, mag});
        sample_sum = phase ? (MID_S - mag_ext) : (MID_S + mag_ext);
    end

    logic [OUT_W-1:0] sample_p1;
    logic             vld_p1;
    logic             done_p1;

    always_ff @(posedge G_CLK_TX or negedge reset) begin
        if (!reset) begin
            word_p0   <= '0;
            k_cnt     <= '0;
            bit_idx   <= '0;
            phase     <= 1'b0;
            sample_p1 <= OUT_W'(MID);
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
`ifdef MSK_DIFF_ENC_EN
            diff_q    <= 1'b0;
`endif
        end else if (enable) begin
            if (state == SEND) begin
                sample_p1 <= sat_unsigned(sample_sum);
                vld_p1    <= 1'b1;
                done_p1   <= last_sample;
                k_cnt     <= k_cnt + KW'(1);
                // Bit boundary: phase and differential history update only here.
                if (last_bit) begin
                    phase   <= phase ^ tx_bit;
                    bit_idx <= (bit_idx == B_LAST) ? '0 : bit_idx + BW'(1);
`ifdef MSK_DIFF_ENC_EN
                    diff_q  <= tx_bit;
`endif
                end
            end else begin
                sample_p1 <= OUT_W'(MID);
                vld_p1    <= 1'b0;
                done_p1   <= 1'b0;
            end
            // Counters are already zero here: either idle, or wrapping at the
            // last sample of the previous word.
            if (handshake)
                word_p0 <= data_in;
        end
    end

    assign data_out  = sample_p1;
    assign out_valid = vld_p1 & enable;
    assign word_done = done_p1 & enable;
    assign phase_out = phase;

endmodule

// File: tb/tb_msk_modulator_param.sv
module tb_msk_modulator_param;

    localparam int  DATA_W = 8;
    localparam int  SPB    = 32;
    localparam int  OUT_W  = 8;
    localparam int  NW     = DATA_W * SPB;
    localparam real PI     = 3.14159265358979323846;

`ifdef MSK_DIFF_ENC_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic              clk_tx = 1'b0;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [OUT_W-1:0]  data_out;
    logic              out_valid;
    logic              word_done;
    logic              phase_out;

    msk_modulator_param #(
        .DATA_W(DATA_W),
        .SPB   (SPB),
        .OUT_W (OUT_W)
    ) dut (
        .G_CLK_TX (clk_tx),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .data_out (data_out),
        .out_valid(out_valid),
        .word_done(word_done),
        .phase_out(phase_out)
    );

    always #5 clk_tx = ~clk_tx;

    int n_vec = 0;
    int n_err = 0;

    int got_s [2*NW];
    bit got_v [2*NW];
    bit got_w [2*NW];
    bit got_p [2*NW];
    int exp_s [2*NW];

    bit m_phase = 1'b0;
    bit m_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    function automatic int exp_sample(input bit t, input bit p, input int k);
        real a;
        int  r;
        a = 127.0 * $sin(PI * real'(t ? 1 : 2) * real'(k) / 31.0);
        r = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
        return p ? 128 - r : 128 + r;
    endfunction

    // Expected samples of one word starting at exp_s[base]; advances model state.
    task automatic model_word(input logic [7:0] w, input int base);
        for (int b = 0; b < DATA_W; b++) begin
            bit t;
            t = w[b] ^ (DIFF & m_prev);
            for (int k = 0; k < SPB; k++)
                exp_s[base + b*SPB + k] = exp_sample(t, m_phase, k);
            m_phase = m_phase ^ t;
            m_prev  = t;
        end
    endtask

    task automatic record(input int i);
        got_s[i] = int'(data_out);
        got_v[i] = out_valid;
        got_w[i] = word_done;
        got_p[i] = phase_out;
    endtask

    task automatic run_word(input logic [7:0] w, input string tag);
        model_word(w, 0);
        in_valid = 1'b1;
        data_in  = w;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        data_in  = '0;
        for (int i = 0; i < NW; i++) begin
            tick();
            record(i);
        end
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_s%0d", tag, i), got_s[i], exp_s[i]);
            chk($sformatf("%s_v%0d", tag, i), got_v[i], 1);
            chk($sformatf("%s_wd%0d", tag, i), got_w[i], (i == NW - 1) ? 1 : 0);
        end
        chk({tag, "_phase_end"}, phase_out, m_phase);
        tick();
        chk({tag, "_idle_vld"}, out_valid, 0);
        chk({tag, "_idle_out"}, data_out, 128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        int nv;
        int nwd;
        int froz;
        bit exp_ph_mid;

        reset    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;

        // Scenario 1: reset values, then release
        tick();
        tick();
        chk("rst_out", data_out, 128);
        chk("rst_vld", out_valid, 0);
        chk("rst_wd", word_done, 0);
        chk("rst_ph", phase_out, 0);
        reset = 1'b1;
        tick();
        chk("rel_out", data_out, 128);
        chk("rel_vld", out_valid, 0);
        chk("rel_rdy", in_ready, 1);
        chk("rel_ph", phase_out, 0);

        // Scenario 2: word 0x00
        run_word(8'h00, "w00");
        for (int b = 0; b < DATA_W; b++) begin
            chk($sformatf("w00_b%0d_k0", b), got_s[b*SPB], 128);
            chk($sformatf("w00_b%0d_k8", b), got_s[b*SPB + 8], 255);
            chk($sformatf("w00_b%0d_k31", b), got_s[b*SPB + 31], 128);
        end
        chk("w00_phase", phase_out, 0);

        // Scenario 3: word 0x01
        run_word(8'h01, "w01");
        chk("w01_b0_k15", got_s[15], 255);
        chk("w01_b0_k31", got_s[31], 128);
        chk("w01_ph_b0", got_p[10], 0);
`ifndef MSK_DIFF_ENC_EN
        chk("w01_b1_k8", got_s[40], 1);
        chk("w01_ph_b1", got_p[40], 1);
        chk("w01_ph_end", phase_out, 1);
`endif

        // Scenario 5: enable drop at bit 3, k = 10, then reset mid-word
        model_word(8'h00, 0);
        in_valid = 1'b1;
        data_in  = 8'h00;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i <= 3*SPB + 10; i++) begin
            tick();
            record(i);
        end
        chk("en_pre_k10", got_s[3*SPB + 10], exp_s[3*SPB + 10]);
        froz     = got_s[3*SPB + 10];
        enable   = 1'b0;
        in_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("en_off_rdy%0d", c), in_ready, 0);
            tick();
            chk($sformatf("en_off_out%0d", c), data_out, froz);
            chk($sformatf("en_off_vld%0d", c), out_valid, 0);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();
        chk("en_resume_k11", data_out, exp_s[3*SPB + 11]);
        chk("en_resume_vld", out_valid, 1);
        for (int c = 0; c < 20; c++)
            tick();
        chk("mid_vld", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_out", data_out, 128);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_wd", word_done, 0);
        chk("mrst_ph", phase_out, 0);
        m_phase = 1'b0;
        m_prev  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("mrel_vld", out_valid, 0);
        chk("mrel_out", data_out, 128);
        chk("mrel_rdy", in_ready, 1);

        // Scenario 4: back-to-back 0xFF then 0x00 with in_valid held
        model_word(8'hFF, 0);
        exp_ph_mid = m_phase;
        model_word(8'h00, NW);
        hs       = 0;
        in_valid = 1'b1;
        data_in  = 8'hFF;
        #1;
        if (in_ready) hs++;
        tick();
        data_in = 8'h00;
        for (int i = 0; i < 2*NW; i++) begin
            if (in_valid && in_ready) hs++;
            tick();
            if (hs == 2) in_valid = 1'b0;
            record(i);
        end
        chk("b2b_handshakes", hs, 2);
        nv  = 0;
        nwd = 0;
        for (int i = 0; i < 2*NW; i++) begin
            nv  += int'(got_v[i]);
            nwd += int'(got_w[i]);
            chk($sformatf("b2b_s%0d", i), got_s[i], exp_s[i]);
        end
        chk("b2b_valid_cnt", nv, 2*NW);
        chk("b2b_wd_cnt", nwd, 2);
        chk("b2b_wd_first", got_w[NW-1], 1);
        chk("b2b_wd_second", got_w[2*NW-1], 1);
        chk("b2b_ph_mid", got_p[NW-1], exp_ph_mid);
        chk("b2b_ph_mid_abs", got_p[NW-1], 0);
        tick();
        chk("b2b_idle_vld", out_valid, 0);
        chk("b2b_idle_out", data_out, 128);

`ifdef MSK_DIFF_ENC_EN
        // Scenario 6: differential encoding of 0x01 from reset
        reset = 1'b0;
        m_phase = 1'b0;
        m_prev  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        run_word(8'h01, "diff01");
        begin
            int tog;
            bit pv;
            tog = 0;
            pv  = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (got_p[i] != pv) tog++;
                pv = got_p[i];
            end
            chk("diff_toggles", tog, 8);
            chk("diff_b1_k15", got_s[SPB + 15], 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
